// File: rtl/regfile_wport_arb.sv
// regfile_wport_arb: round-robin arbiter sharing NPORT register-file write
// ports among NREQ writeback requesters. No two grants in one cycle ever
// target the same register, so write ordering within a cycle is defined.
// Optional feature macro ARB_FIXED0_EN: requester 0 always owns port 0 when
// valid, and the round-robin pointer rotates only over requesters 1..NREQ-1.
module regfile_wport_arb #(
    parameter int NREQ  = 4,
    parameter int NPORT = 2,
    parameter int AW    = 6,
    parameter int DW    = 32,
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int QW   = (NPORT > 1) ? $clog2(NPORT) : 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  flush,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*AW-1:0]    req_addr,
    input  logic [NREQ*DW-1:0]    req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic [NPORT-1:0]      wr_en,
    output logic [NPORT*AW-1:0]   wr_addr,
    output logic [NPORT*DW-1:0]   wr_data,
    output logic [PW-1:0]         rr_ptr
);

    logic [NPORT-1:0]            wr_en_q,   wr_en_d;
    logic [NPORT*AW-1:0]         wr_addr_q, wr_addr_d;
    logic [NPORT*DW-1:0]         wr_data_q, wr_data_d;
    logic [PW-1:0]               rr_ptr_q,  rr_ptr_d;

    logic [NREQ-1:0][PW-1:0]     scan_order_s;   // requester visited at each scan slot
    logic [NREQ-1:0]             scan_rr_s;      // slot participates in pointer rotation
    logic [NREQ-1:0]             grant_s;
    logic [NPORT-1:0]            port_vld_s;
    logic [NPORT-1:0][AW-1:0]    port_addr_s;
    logic [NPORT-1:0][DW-1:0]    port_data_s;
    logic [QW:0]                 n_grant_s;      // one spare bit so it can hold NPORT
    logic [PW-1:0]               idx_s;
    logic [PW-1:0]               last_s;
    logic                        adv_s;
    logic                        conflict_s;
`ifdef ARB_FIXED0_EN
    int                          scan_base_s;
`endif

    // Build the order in which requesters are considered this cycle.
    always_comb begin
        scan_order_s = '0;
        scan_rr_s    = '0;
`ifdef ARB_FIXED0_EN
        // Requester 0 is always first and never moves the pointer; the rest
        // rotate over 1..NREQ-1, with a pointer value of 0 treated as 1.
        scan_base_s     = (rr_ptr_q == '0) ? 0 : int'(rr_ptr_q) - 1;
        scan_order_s[0] = '0;
        scan_rr_s[0]    = 1'b0;
        for (int k = 1; k < NREQ; k++) begin
            scan_order_s[k] = PW'(1 + ((scan_base_s + k - 1) % (NREQ - 1)));
            scan_rr_s[k]    = 1'b1;
        end
`else
        for (int k = 0; k < NREQ; k++) begin
            scan_order_s[k] = PW'((int'(rr_ptr_q) + k) % NREQ);
            scan_rr_s[k]    = 1'b1;
        end
`endif
    end

    // Walk the scan order, granting valid requesters whose address is not
    // already taken this cycle, filling ports 0,1,... until they run out.
    always_comb begin
        grant_s     = '0;
        port_vld_s  = '0;
        port_addr_s = '0;
        port_data_s = '0;
        n_grant_s   = '0;
        last_s      = rr_ptr_q;
        adv_s       = 1'b0;
        conflict_s  = 1'b0;
        idx_s       = '0;
        if (rstn && !flush) begin
            for (int k = 0; k < NREQ; k++) begin
                idx_s      = scan_order_s[k];
                conflict_s = 1'b0;
                for (int p = 0; p < NPORT; p++) begin
                    conflict_s = conflict_s |
                                 (port_vld_s[p] & (port_addr_s[p] == req_addr[idx_s*AW +: AW]));
                end
                if (req_valid[idx_s] && !conflict_s && (n_grant_s < (QW+1)'(NPORT))) begin
                    grant_s[idx_s]                   = 1'b1;
                    port_vld_s[n_grant_s[QW-1:0]]    = 1'b1;
                    port_addr_s[n_grant_s[QW-1:0]]   = req_addr[idx_s*AW +: AW];
                    port_data_s[n_grant_s[QW-1:0]]   = req_data[idx_s*DW +: DW];
                    n_grant_s                        = n_grant_s + {{QW{1'b0}}, 1'b1};
                    if (scan_rr_s[k]) begin
                        last_s = idx_s;
                        adv_s  = 1'b1;
                    end else begin
                        last_s = last_s;
                    end
                end else begin
                    grant_s = grant_s;
                end
            end
        end else begin
            grant_s = '0;
        end
    end

    // Next-state: pointer moves past the last rotating grant; idle ports keep
    // their address/data so the bus only toggles on real writes.
    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        wr_en_d   = port_vld_s;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (adv_s) begin
`ifdef ARB_FIXED0_EN
            rr_ptr_d = (last_s == PW'(NREQ - 1)) ? PW'(1) : last_s + PW'(1);
`else
            rr_ptr_d = (last_s == PW'(NREQ - 1)) ? PW'(0) : last_s + PW'(1);
`endif
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
        for (int p = 0; p < NPORT; p++) begin
            if (port_vld_s[p]) begin
                wr_addr_d[p*AW +: AW] = port_addr_s[p];
                wr_data_d[p*DW +: DW] = port_data_s[p];
            end else begin
                wr_addr_d[p*AW +: AW] = wr_addr_q[p*AW +: AW];
                wr_data_d[p*DW +: DW] = wr_data_q[p*DW +: DW];
            end
        end
    end

    // Register the port outputs and pointer; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_en_q   <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rr_ptr_q  <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    assign req_ready = grant_s;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign rr_ptr    = rr_ptr_q;

endmodule
